// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU request/response and data-memory signals of the store buffer.
// Handshake: there is no valid/ready pair. A CPU request (cpu_mem_read or
// cpu_mem_write) completes at the rising edge of any cycle in which cpu_stall
// is 0; while cpu_stall is 1 the CPU must hold the same request unchanged.
// mem_read/mem_write are single-cycle strobes to a memory that always
// completes in the cycle they are raised.
// The slave modport is the store buffer; the master modport is its environment.
interface store_buffer_if #(
  parameter int AW = 32
) ();
  logic          cpu_mem_read;
  logic          cpu_mem_write;
  logic [AW-1:0] cpu_address;
  logic [31:0]   cpu_write_data;
  logic [31:0]   cpu_read_data;
  logic          cpu_stall;
  logic          sb_empty;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data, mem_read_data,
    output cpu_read_data, cpu_stall, sb_empty, mem_read, mem_write, mem_address,
           mem_write_data
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data, mem_read_data,
    input  cpu_read_data, cpu_stall, sb_empty, mem_read, mem_write, mem_address,
           mem_write_data
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending CPU stores, drained to data memory
// whenever the memory port is not needed by a load.
// Optional feature macro: STORE_BUFFER_FWD_EN -- when defined, loads that hit a
// buffered store are served from the youngest matching entry; otherwise such
// loads stall until the matching entries have drained to memory.
// A cycle with both cpu_mem_read and cpu_mem_write is a store; the read flag
// still reserves the memory port, so no drain happens in that cycle.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  store_buffer_if.slave sb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = AW - 2;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Queue state
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WW-1:0]    addr_q [DEPTH];
  logic [WW-1:0]    addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  // Request decode and lookup results
  logic [WW-1:0] word_addr;
  logic          load_req;
  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] scan_idx;
  logic          ld_hit;
  logic          full;
  logic          accept;
  logic          drain;
  logic          mem_rd;

  assign word_addr = sb.cpu_address[AW-1:2];
  assign load_req  = sb.cpu_mem_read & ~sb.cpu_mem_write;

  // Address match against valid entries, oldest to youngest so the youngest wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PW'(k);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == word_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[scan_idx];
      end
    end
  end

  // Memory port arbitration and CPU-facing outputs
  always_comb begin
    ld_hit = load_req & hit;
    full   = (count_q == FULL_CNT);
    accept = sb.cpu_mem_write & ~full;
    // A load hitting the buffer never uses the port, so draining continues
    drain  = (count_q != '0) & (~sb.cpu_mem_read | ld_hit);
    // No memory traffic is issued while reset is held
    mem_rd = load_req & ~hit & rst_n;

    sb.mem_read       = mem_rd;
    sb.mem_write      = drain;
    sb.mem_address    = '0;
    sb.mem_write_data = '0;
    if (mem_rd) begin
      sb.mem_address = sb.cpu_address;
    end else if (drain) begin
      sb.mem_address    = {addr_q[head_q], 2'b00};
      sb.mem_write_data = data_q[head_q];
    end

`ifdef STORE_BUFFER_FWD_EN
    sb.cpu_stall     = sb.cpu_mem_write & full;
    sb.cpu_read_data = ld_hit ? hit_data : (mem_rd ? sb.mem_read_data : 32'h0);
`else
    sb.cpu_stall     = (sb.cpu_mem_write & full) | ld_hit;
    sb.cpu_read_data = mem_rd ? sb.mem_read_data : 32'h0;
`endif
    sb.sb_empty = (count_q == '0);
  end

  // Pointer, count and valid next state
  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(accept);
    count_d = count_q + (PW+1)'(accept) - (PW+1)'(drain);
    valid_d = valid_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
    end
  end

  // Entry payload next state: write the tail slot on accept
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      addr_d[tail_q] = word_addr;
      data_d[tail_q] = sb.cpu_write_data;
    end
  end

  // Control state with asynchronous clear; pending entries are simply dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage, no reset needed since valid_q qualifies it
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4, AW=32).
// A small word memory model answers mem_read combinationally and logs every
// mem_write, so drain order can be checked against an expected queue.
module tb_store_buffer;

  localparam int AW = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  store_buffer_if #(.AW(AW)) sbif ();

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and write log ----------------
  logic [31:0] mem_model [0:255];
  logic [63:0] wr_log [$];
  logic [63:0] exp_q [$];

  assign sbif.mem_read_data = mem_model[sbif.mem_address[9:2]];

  always @(posedge clk) begin
    if (rst_n && sbif.mem_write) begin
      mem_model[sbif.mem_address[9:2]] <= sbif.mem_write_data;
      wr_log.push_back({sbif.mem_address, sbif.mem_write_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
    sbif.cpu_mem_read   = rd;
    sbif.cpu_mem_write  = wr;
    sbif.cpu_address    = addr;
    sbif.cpu_write_data = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Run idle cycles until the buffer reports empty (bounded); caller checks sb_empty
  task automatic drain_wait();
    int n;
    n = 0;
    idle();
    @(negedge clk);
    while (sbif.sb_empty !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", sbif.sb_empty); end
    checks++; if (sbif.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", sbif.cpu_stall); end
    checks++; if (sbif.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", sbif.mem_write); end
    checks++; if (sbif.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", sbif.mem_read); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_store();
    wr_log.delete();
    drive(1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (sbif.cpu_stall !== 1'b0) begin errors++; $display("FAIL single_accept_stall: got %b want 0", sbif.cpu_stall); end
    checks++; if (sbif.mem_write !== 1'b0) begin errors++; $display("FAIL single_no_same_cycle_drain: got %b want 0", sbif.mem_write); end
    cyc();
    idle();
    @(negedge clk);
    checks++; if (sbif.mem_write !== 1'b1) begin errors++; $display("FAIL single_drain_write: got %b want 1", sbif.mem_write); end
    checks++; if (sbif.mem_address !== 32'h100) begin errors++; $display("FAIL single_drain_addr: got %h want 00000100", sbif.mem_address); end
    checks++; if (sbif.mem_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_drain_data: got %h want deadbeef", sbif.mem_write_data); end
    checks++; if (sbif.sb_empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b want 0", sbif.sb_empty); end
    cyc();
    @(negedge clk);
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b want 1", sbif.sb_empty); end
    checks++; if (sbif.mem_write !== 1'b0) begin errors++; $display("FAIL single_idle_write: got %b want 0", sbif.mem_write); end
    checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL single_write_count: got %0d want 1", wr_log.size()); end
    cyc();
  endtask

  // Stores issued with cpu_mem_read held high keep the port reserved: no drain
  task automatic test_full_stall();
    logic [63:0] exp_w [5];
    exp_w[0] = {32'h0,  32'h1};
    exp_w[1] = {32'h4,  32'h2};
    exp_w[2] = {32'h8,  32'h3};
    exp_w[3] = {32'hC,  32'h4};
    exp_w[4] = {32'h10, 32'h5};
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(4 * i), 32'(i + 1));
      cyc();
    end
    drive(1'b0, 1'b1, 32'h10, 32'h5);
    @(negedge clk);
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL full_no_early_drain: got %0d writes want 0", wr_log.size()); end
    checks++; if (sbif.cpu_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", sbif.cpu_stall); end
    checks++; if (sbif.mem_write !== 1'b1) begin errors++; $display("FAIL full_drain_on_stall: got %b want 1", sbif.mem_write); end
    checks++; if (sbif.mem_address !== 32'h0) begin errors++; $display("FAIL full_drain_addr: got %h want 00000000", sbif.mem_address); end
    cyc();
    @(negedge clk);
    checks++; if (sbif.cpu_stall !== 1'b0) begin errors++; $display("FAIL full_stall_one_cycle: got %b want 0", sbif.cpu_stall); end
    checks++; if (sbif.mem_address !== 32'h4) begin errors++; $display("FAIL full_drain2_addr: got %h want 00000004", sbif.mem_address); end
    cyc();
    drain_wait();
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL full_drain_timeout: sb_empty got %b want 1", sbif.sb_empty); end
    checks++; if (wr_log.size() !== 5) begin errors++; $display("FAIL full_write_count: got %0d want 5", wr_log.size()); end
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_w[i]) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, wr_log[i], exp_w[i]); end
    end
    cyc();
  endtask

  // Two stores to 0x40 then a load of 0x40; the first store drains while the
  // second is being accepted, so one matching entry remains at load time
  task automatic test_forward();
    int stalls;
    logic [31:0] rd_first;
    wr_log.delete();
    drive(1'b0, 1'b1, 32'h40, 32'h1);
    cyc();
    drive(1'b0, 1'b1, 32'h40, 32'h2);
    cyc();
    drive(1'b1, 1'b0, 32'h40, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
    @(negedge clk);
    checks++; if (sbif.cpu_read_data !== 32'h2) begin errors++; $display("FAIL fwd_data: got %h want 00000002", sbif.cpu_read_data); end
    checks++; if (sbif.cpu_stall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b want 0", sbif.cpu_stall); end
    checks++; if (sbif.mem_read !== 1'b0) begin errors++; $display("FAIL fwd_mem_read: got %b want 0", sbif.mem_read); end
    checks++; if (sbif.mem_write_data !== 32'h2) begin errors++; $display("FAIL fwd_drain_data: got %h want 00000002", sbif.mem_write_data); end
    stalls = 0;
    rd_first = 32'h0;
`else
    @(negedge clk);
    rd_first = sbif.cpu_read_data;
    stalls = 0;
    while (sbif.cpu_stall === 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    checks++; if (stalls !== 1) begin errors++; $display("FAIL nofwd_stall_cycles: got %0d want 1", stalls); end
    checks++; if (rd_first !== 32'h0) begin errors++; $display("FAIL nofwd_data_while_stalled: got %h want 00000000", rd_first); end
    checks++; if (sbif.mem_read !== 1'b1) begin errors++; $display("FAIL nofwd_mem_read: got %b want 1", sbif.mem_read); end
    checks++; if (sbif.mem_address !== 32'h40) begin errors++; $display("FAIL nofwd_mem_addr: got %h want 00000040", sbif.mem_address); end
    checks++; if (sbif.cpu_read_data !== 32'h2) begin errors++; $display("FAIL nofwd_mem_data: got %h want 00000002", sbif.cpu_read_data); end
`endif
    cyc();
    drain_wait();
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_drain_timeout: sb_empty got %b want 1", sbif.sb_empty); end
    checks++; if (mem_model[16] !== 32'h2) begin errors++; $display("FAIL fwd_final_mem: got %h want 00000002", mem_model[16]); end
    cyc();
  endtask

  task automatic test_load_miss();
    wr_log.delete();
    drive(1'b0, 1'b1, 32'h40, 32'h7);
    cyc();
    drive(1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checks++; if (sbif.mem_read !== 1'b1) begin errors++; $display("FAIL miss_mem_read: got %b want 1", sbif.mem_read); end
    checks++; if (sbif.mem_write !== 1'b0) begin errors++; $display("FAIL miss_no_write: got %b want 0", sbif.mem_write); end
    checks++; if (sbif.mem_address !== 32'h44) begin errors++; $display("FAIL miss_addr: got %h want 00000044", sbif.mem_address); end
    checks++; if (sbif.cpu_read_data !== 32'h12345678) begin errors++; $display("FAIL miss_data: got %h want 12345678", sbif.cpu_read_data); end
    checks++; if (sbif.cpu_stall !== 1'b0) begin errors++; $display("FAIL miss_stall: got %b want 0", sbif.cpu_stall); end
    cyc();
    drive(1'b1, 1'b1, 32'h48, 32'h9);
    @(negedge clk);
    checks++; if (sbif.cpu_read_data !== 32'h0) begin errors++; $display("FAIL rdwr_read_data: got %h want 00000000", sbif.cpu_read_data); end
    checks++; if (sbif.mem_read !== 1'b0) begin errors++; $display("FAIL rdwr_mem_read: got %b want 0", sbif.mem_read); end
    cyc();
    idle();
    @(negedge clk);
    checks++; if (sbif.cpu_read_data !== 32'h0) begin errors++; $display("FAIL idle_read_data: got %h want 00000000", sbif.cpu_read_data); end
    checks++; if (sbif.mem_address !== 32'h40) begin errors++; $display("FAIL idle_drain_addr: got %h want 00000040", sbif.mem_address); end
    cyc();
    drain_wait();
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL miss_drain_timeout: sb_empty got %b want 1", sbif.sb_empty); end
    checks++; if (sbif.mem_address !== 32'h0) begin errors++; $display("FAIL idle_mem_addr_zero: got %h want 00000000", sbif.mem_address); end
    checks++; if (mem_model[18] !== 32'h9) begin errors++; $display("FAIL rdwr_store_written: got %h want 00000009", mem_model[18]); end
    cyc();
  endtask

  task automatic test_reset_mid();
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h0C0 + 32'(4 * i), 32'hBAD0 + 32'(i));
      cyc();
    end
    drive(1'b1, 1'b0, 32'h300, 32'h0);
    #2;
    checks++; if (sbif.sb_empty !== 1'b0) begin errors++; $display("FAIL midrst_filled: sb_empty got %b want 0", sbif.sb_empty); end
    rst_n = 1'b0;
    #1;
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", sbif.sb_empty); end
    checks++; if (sbif.mem_write !== 1'b0) begin errors++; $display("FAIL midrst_mem_write: got %b want 0", sbif.mem_write); end
    checks++; if (sbif.mem_read !== 1'b0) begin errors++; $display("FAIL midrst_mem_read: got %b want 0", sbif.mem_read); end
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    @(negedge clk);
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL midrst_no_writes: got %0d want 0", wr_log.size()); end
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL midrst_still_empty: got %b want 1", sbif.sb_empty); end
    cyc();
  endtask

  task automatic test_wrap();
    wr_log.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'h80 + 32'(4 * i), 32'hA000 + 32'(i));
      exp_q.push_back({32'h80 + 32'(4 * i), 32'hA000 + 32'(i)});
      cyc();
      if (i % 3 == 2) begin
        idle();
        cyc();
      end
    end
    drain_wait();
    checks++; if (sbif.sb_empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_timeout: sb_empty got %b want 1", sbif.sb_empty); end
    checks++; if (wr_log.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
    cyc();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    mem_model[17] = 32'h12345678;
    test_reset();
    test_single_store();
    test_full_stall();
    test_forward();
    test_load_miss();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_mem_read  input  1  load request this cycle.
REQ-006 SHALL have port cpu_mem_write  input  1  store request this cycle.
REQ-007 SHALL have port cpu_address  input  AW  byte address; word index = cpu_address[AW-1:2].
REQ-008 SHALL have port cpu_write_data  input  32  store data.
REQ-009 SHALL have port cpu_read_data  output  32  load result, combinational.
REQ-010 SHALL have port cpu_stall  output  1  request cannot complete this cycle; CPU holds request.
REQ-011 SHALL have port sb_empty  output  1  no valid entries.
REQ-012 SHALL have ports mem_read, mem_write  output  1 each  data-memory controls.
REQ-013 SHALL have ports mem_address  output  AW, mem_write_data  output  32  data-memory address and data.
REQ-014 SHALL have port mem_read_data  input  32  combinational data-memory read result.

Function
REQ-015 SHALL hold stores in an in-order FIFO of DEPTH entries {word address, data}, with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-016 SHALL accept a store (cpu_mem_write=1, count<DEPTH) at the clock edge; cpu_stall=0.
REQ-017 SHALL assert cpu_stall when cpu_mem_write=1 and count=DEPTH; store not captured that cycle.
REQ-018 SHALL treat cpu_mem_read=1 with cpu_mem_write=1 as a store only; cpu_read_data=0.
REQ-019 Memory port SHALL be owned by a load when cpu_mem_read=1 and the load is not satisfied by forwarding; then mem_read=1, mem_address=cpu_address, cpu_read_data=mem_read_data.
REQ-020 When the port is not owned by a load and count>0, SHALL drain the head entry: mem_write=1, mem_address={head addr,2'b00}, mem_write_data=head data; head advances at that edge.
REQ-021 An entry accepted at edge N SHALL be drainable no earlier than the cycle following edge N (minimum store-to-memory latency 1 cycle).
REQ-022 Simultaneous accept and drain in one cycle SHALL leave count unchanged; a full buffer with a stalled store SHALL drain that cycle (no load present) and accept the store on the next cycle.
REQ-023 mem_read and mem_write SHALL never both be 1; all mem_* outputs SHALL be 0 when idle.
REQ-024 cpu_read_data SHALL be 0 when cpu_mem_read=0.
REQ-025 sb_empty SHALL equal (count==0).

Reset
REQ-026 SHALL, on rst_n=0, asynchronously clear count, head, tail and all valid state; sb_empty=1, cpu_stall=0, mem_write=0, mem_read=0.
REQ-027 Pending entries at reset SHALL be discarded with no memory write; entry data contents need not be cleared.

Configuration
REQ-028 Macro STORE_BUFFER_FWD_EN SHALL control load forwarding.
REQ-029 With STORE_BUFFER_FWD_EN defined: a load whose word address matches any valid entry SHALL return the youngest matching entry's data combinationally, mem_read=0, cpu_stall=0, and drain proceeds that cycle.
REQ-030 Without STORE_BUFFER_FWD_EN: a load matching any valid entry SHALL assert cpu_stall with mem_read=0 and cpu_read_data=0, draining one entry per cycle until no match, then complete from memory.
REQ-031 Non-matching loads SHALL behave identically in both builds.

Verification
REQ-032 Reset, then store 0x100<-0xDEADBEEF with no loads -> next cycle mem_write=1, mem_address=0x100, mem_write_data=0xDEADBEEF; then sb_empty=1.
REQ-033 Four back-to-back stores (0x0,0x4,0x8,0xC) while loading 0x200 every cycle -> no drain, count=4; a fifth store -> cpu_stall=1 for exactly one cycle, then accepted.
REQ-034 Store 0x40<-1, store 0x40<-2, load 0x40 next cycle -> FWD build: cpu_read_data=2, cpu_stall=0; non-FWD build: cpu_stall=1 until both drained, then cpu_read_data=2 from memory.
REQ-035 Load 0x44 with buffer holding only 0x40 -> mem_read=1, mem_address=0x44, cpu_read_data=mem_read_data.
REQ-036 Fill 3 entries, assert rst_n=0 mid-cycle -> sb_empty=1 immediately, no subsequent mem_write.
REQ-037 Wrap test: 10 stores interleaved with drains -> memory receives all 10 in issue order, no loss or duplication.
